// File: rtl/bricks_pkg.sv
// Shared grid geometry, ball direction codes and game state encoding for the bricks game.
package bricks_pkg;

    localparam int ROWS       = 12;
    localparam int COLS       = 16;
    localparam int FIELD_BITS = ROWS * COLS;
    localparam int PADDLE_ROW = ROWS - 1;

    localparam logic [1:0] DIR_UP_RIGHT   = 2'b00;
    localparam logic [1:0] DIR_UP_LEFT    = 2'b01;
    localparam logic [1:0] DIR_DOWN_RIGHT = 2'b10;
    localparam logic [1:0] DIR_DOWN_LEFT  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_RUN   = 3'd2,
        ST_OVER  = 3'd3,
        ST_WIN   = 3'd4
    } game_state_t;

    // Flattened field bus position of a cell; callers guarantee the cell is on the grid.
    function automatic logic [7:0] cell_index(input int row, input int col);
        return 8'(row * COLS + col);
    endfunction

endpackage

// File: rtl/bricks_tick_gen.sv
// Divides the clock down to the one-cycle ball step pulse; count restarts whenever cleared.
module bricks_tick_gen #(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic step
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign step = enable && (count == LAST);

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= step ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/bricks_game_ctrl.sv
// Bricks game sequencer: owns brick map, paddle, score and lives, and paces the ball mover.
module bricks_game_ctrl
    import bricks_pkg::*;
#(
    parameter int TICK_DIV   = 5_000_000,
    parameter int LIVES      = 3,
    parameter int BRICK_ROWS = 4,
    parameter int PAD_W      = 4,
    parameter int SCORE_W    = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pad_left,
    input  logic                  pad_right,
    input  logic [3:0]            Ball_rowIndex,
    input  logic [3:0]            Ball_colIndex,
    input  logic [1:0]            Ball_direction,
    output logic [FIELD_BITS-1:0] field_data,
    output logic                  ball_step,
    output logic                  ball_reset,
    output logic [3:0]            paddle_col,
    output logic [2:0]            lives,
    output logic [SCORE_W-1:0]    score,
    output logic [2:0]            game_state
);

    localparam logic [FIELD_BITS-1:0] BRICK_INIT =
        (FIELD_BITS'(1) << (BRICK_ROWS * COLS)) - FIELD_BITS'(1);
    localparam logic [15:0] PAD_MASK   = 16'((17'(1) << PAD_W) - 17'(1));
    localparam logic [3:0]  PAD_MAX    = 4'(COLS - PAD_W);
    localparam logic [3:0]  PAD_INIT   = 4'((COLS - PAD_W) / 2);
    localparam logic [2:0]  LIVES_INIT = 3'(LIVES);

    game_state_t state, state_next;
    logic [FIELD_BITS-1:0] bricks, bricks_next;
    logic [3:0]            paddle_q, paddle_next;
    logic [2:0]            lives_q, lives_next;
    logic [SCORE_W-1:0]    score_q, score_next;
    logic                  start_q;

    logic                  start_edge;
    logic                  in_run;
    int                    ball_r, ball_c, v_row, h_col;
    logic                  going_down, col_up;
    logic                  v_hit, h_hit, d_hit, miss;
    logic [FIELD_BITS-1:0] clear_mask;
    logic [1:0]            cleared_cnt;
    logic [SCORE_W:0]      score_sum;
    logic [15:0]           pad_row;

    assign start_edge = start & ~start_q;
    assign in_run     = (state == ST_RUN);

    function automatic logic is_brick(input logic [FIELD_BITS-1:0] map, input int row, input int col);
        if (row >= 0 && row < BRICK_ROWS && col >= 0 && col < COLS) begin
            return map[cell_index(row, col)];
        end
        return 1'b0;
    endfunction

    function automatic logic is_paddle(input logic [3:0] pcol, input int col);
        return (col >= 0) && (col < COLS) && (col >= int'(pcol)) && (col < int'(pcol) + PAD_W);
    endfunction

    bricks_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .clear (!in_run),
        .enable(in_run),
        .step  (ball_step)
    );

    // Neighbour cells of the ball are judged on its pre-step position; vertical and
    // horizontal hits take priority, the diagonal only counts when both are empty.
    always_comb begin
        ball_r      = int'(Ball_rowIndex);
        ball_c      = int'(Ball_colIndex);
        going_down  = (Ball_direction == DIR_DOWN_RIGHT) || (Ball_direction == DIR_DOWN_LEFT);
        col_up      = (Ball_direction == DIR_UP_LEFT) || (Ball_direction == DIR_DOWN_LEFT);
        v_row       = going_down ? ball_r + 1 : ball_r - 1;
        h_col       = col_up ? ball_c + 1 : ball_c - 1;
        v_hit       = is_brick(bricks, v_row, ball_c);
        h_hit       = is_brick(bricks, ball_r, h_col);
        d_hit       = is_brick(bricks, v_row, h_col);
        clear_mask  = '0;
        cleared_cnt = 2'd0;
        if (v_hit || h_hit) begin
            if (v_hit) begin
                clear_mask[cell_index(v_row, ball_c)] = 1'b1;
                cleared_cnt = cleared_cnt + 2'd1;
            end
            if (h_hit) begin
                clear_mask[cell_index(ball_r, h_col)] = 1'b1;
                cleared_cnt = cleared_cnt + 2'd1;
            end
        end else if (d_hit) begin
            clear_mask[cell_index(v_row, h_col)] = 1'b1;
            cleared_cnt = 2'd1;
        end
        miss = (ball_r == PADDLE_ROW - 1) && going_down &&
               !is_paddle(paddle_q, ball_c) && !is_paddle(paddle_q, h_col);
        score_sum = {1'b0, score_q} + (SCORE_W + 1)'(cleared_cnt);
    end

    always_comb begin
        state_next  = state;
        bricks_next = bricks;
        paddle_next = paddle_q;
        lives_next  = lives_q;
        score_next  = score_q;
        case (state)
            ST_IDLE: begin
                bricks_next = BRICK_INIT;
                paddle_next = PAD_INIT;
                lives_next  = LIVES_INIT;
                score_next  = '0;
                if (start_edge) state_next = ST_SERVE;
            end
            ST_SERVE: begin
                if (start_edge) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (ball_step) begin
                    bricks_next = bricks & ~clear_mask;
                    score_next  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                    if (pad_left && !pad_right && paddle_q < PAD_MAX) begin
                        paddle_next = paddle_q + 4'd1;
                    end else if (pad_right && !pad_left && paddle_q != 4'd0) begin
                        paddle_next = paddle_q - 4'd1;
                    end
                    if (miss) begin
                        lives_next = lives_q - 3'd1;
                        state_next = (lives_q == 3'd1) ? ST_OVER : ST_SERVE;
                    end
                end else if (bricks == '0) begin
                    state_next = ST_WIN;
                end
            end
            ST_OVER, ST_WIN: begin
                if (start_edge) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_IDLE;
            bricks   <= BRICK_INIT;
            paddle_q <= PAD_INIT;
            lives_q  <= LIVES_INIT;
            score_q  <= '0;
            start_q  <= 1'b0;
        end else begin
            state    <= state_next;
            bricks   <= bricks_next;
            paddle_q <= paddle_next;
            lives_q  <= lives_next;
            score_q  <= score_next;
            start_q  <= start;
        end
    end

    assign pad_row    = PAD_MASK << paddle_q;
    assign field_data = bricks | (FIELD_BITS'(pad_row) << (PADDLE_ROW * COLS));
    assign ball_reset = in_run;
    assign paddle_col = paddle_q;
    assign lives      = lives_q;
    assign score      = score_q;
    assign game_state = state;

endmodule

// File: tb/tb_bricks_game_ctrl.sv
// Scoreboard bench for bricks_game_ctrl: expected post-step results queue up, a monitor checks each ball_step.
module tb_bricks_game_ctrl;

    localparam int TICK_DIV = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         pad_left = 1'b0;
    logic         pad_right = 1'b0;
    logic [3:0]   ball_row = 4'd8;
    logic [3:0]   ball_col = 4'd8;
    logic [1:0]   ball_dir = 2'b00;
    logic [191:0] field_data;
    logic         ball_step;
    logic         ball_reset;
    logic [3:0]   paddle_col;
    logic [2:0]   lives;
    logic [7:0]   score;
    logic [2:0]   game_state;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string        name;
        logic [2:0]   state;
        logic [2:0]   lives;
        logic [7:0]   score;
        logic [3:0]   paddle;
        logic         ball_reset;
        logic [191:0] field;
    } exp_t;

    exp_t exp_q[$];

    logic [191:0] exp_bricks;
    logic [3:0]   exp_pad;
    int           exp_score;

    bricks_game_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .LIVES     (3),
        .BRICK_ROWS(4),
        .PAD_W     (4),
        .SCORE_W   (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .pad_left      (pad_left),
        .pad_right     (pad_right),
        .Ball_rowIndex (ball_row),
        .Ball_colIndex (ball_col),
        .Ball_direction(ball_dir),
        .field_data    (field_data),
        .ball_step     (ball_step),
        .ball_reset    (ball_reset),
        .paddle_col    (paddle_col),
        .lives         (lives),
        .score         (score),
        .game_state    (game_state)
    );

    always #5 clock = ~clock;

    function automatic logic [191:0] exp_field();
        return exp_bricks | (192'(4'hF) << (176 + int'(exp_pad)));
    endfunction

    task automatic checkOutput(input string name, input logic [191:0] actual, input logic [191:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] c, input logic [1:0] d,
                                 input logic left, input logic right);
        @(negedge clock);
        ball_row  = r;
        ball_col  = c;
        ball_dir  = d;
        pad_left  = left;
        pad_right = right;
    endtask

    task automatic push_exp(input string name, input logic [2:0] st, input logic [2:0] lv, input int sc);
        exp_t e;
        e.name       = name;
        e.state      = st;
        e.lives      = lv;
        e.score      = 8'(sc);
        e.paddle     = exp_pad;
        e.ball_reset = (st == 3'd2);
        e.field      = exp_field();
        exp_q.push_back(e);
    endtask

    task automatic wait_step();
        int n = 0;
        while (exp_q.size() != 0 && n < 4 * TICK_DIV + 4) begin
            @(posedge clock);
            #2;
            n++;
        end
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL step_timeout: %0d expectations still pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic start_pulse();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Monitor: every step edge pops one expected result and checks the registered outcome.
    always @(negedge clock) begin
        if (ball_step === 1'b1) begin
            @(posedge clock);
            #1;
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_step: ball_step seen with no expectation queued");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput({e.name, ".state"}, 192'(game_state), 192'(e.state));
                checkOutput({e.name, ".lives"}, 192'(lives), 192'(e.lives));
                checkOutput({e.name, ".score"}, 192'(score), 192'(e.score));
                checkOutput({e.name, ".paddle"}, 192'(paddle_col), 192'(e.paddle));
                checkOutput({e.name, ".ball_reset"}, 192'(ball_reset), 192'(e.ball_reset));
                checkOutput({e.name, ".field"}, field_data, e.field);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_bricks = {128'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        exp_pad    = 4'd6;
        exp_score  = 0;

        // 1: reset values
        @(posedge clock);
        #1;
        checkOutput("rst.field", field_data, {6'd0, 4'hF, 118'd0, 64'hFFFF_FFFF_FFFF_FFFF});
        checkOutput("rst.state", 192'(game_state), 192'(0));
        checkOutput("rst.lives", 192'(lives), 192'(3));
        checkOutput("rst.score", 192'(score), 192'(0));
        checkOutput("rst.paddle", 192'(paddle_col), 192'(6));
        checkOutput("rst.ball_reset", 192'(ball_reset), 192'(0));
        checkOutput("rst.ball_step", 192'(ball_step), 192'(0));
        @(negedge clock);
        reset = 1'b1;

        // 2: held start fires once, then step cadence in RUN
        @(negedge clock);
        start = 1'b1;
        repeat (4) @(negedge clock);
        checkOutput("held_start.state", 192'(game_state), 192'(1));
        start = 1'b0;
        for (int i = 0; i < 3; i++) push_exp($sformatf("cadence%0d", i), 3'd2, 3'd3, 0);
        start_pulse();
        checkOutput("serve_to_run.state", 192'(game_state), 192'(2));
        for (int k = 1; k <= 12; k++) begin
            checkOutput($sformatf("step_before_edge%0d", k), 192'(ball_step), 192'(k % 4 == 0));
            if (k < 12) @(negedge clock);
        end
        wait_step();

        // 3: vertical hit then diagonal hit
        applyStimulus(4'd4, 4'd5, 2'b00, 1'b0, 1'b0);
        exp_bricks[53] = 1'b0;
        push_exp("vhit", 3'd2, 3'd3, 1);
        wait_step();
        exp_bricks[52] = 1'b0;
        push_exp("dhit", 3'd2, 3'd3, 2);
        wait_step();

        // 4: three misses lead to OVER, start returns to IDLE with reloads
        applyStimulus(4'd10, 4'd2, 2'b11, 1'b0, 1'b0);
        push_exp("miss1", 3'd1, 3'd2, 2);
        wait_step();
        start_pulse();
        checkOutput("miss1_serve.state", 192'(game_state), 192'(2));
        push_exp("miss2", 3'd1, 3'd1, 2);
        wait_step();
        start_pulse();
        push_exp("miss3", 3'd3, 3'd0, 2);
        wait_step();
        checkOutput("over.ball_step", 192'(ball_step), 192'(0));
        start_pulse();
        checkOutput("over_to_idle.state", 192'(game_state), 192'(0));
        @(negedge clock);
        exp_bricks = {128'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        exp_score  = 0;
        checkOutput("idle_reload.lives", 192'(lives), 192'(3));
        checkOutput("idle_reload.score", 192'(score), 192'(0));
        checkOutput("idle_reload.field", field_data, exp_field());

        // 5: paddle movement and clamping
        start_pulse();
        start_pulse();
        applyStimulus(4'd8, 4'd8, 2'b00, 1'b1, 1'b1);
        push_exp("pad_both0", 3'd2, 3'd3, 0);
        wait_step();
        push_exp("pad_both1", 3'd2, 3'd3, 0);
        wait_step();
        applyStimulus(4'd8, 4'd8, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            exp_pad = (exp_pad == 4'd0) ? 4'd0 : exp_pad - 4'd1;
            push_exp($sformatf("pad_right%0d", i), 3'd2, 3'd3, 0);
            wait_step();
        end
        applyStimulus(4'd8, 4'd8, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 13; i++) begin
            exp_pad = (exp_pad == 4'd12) ? 4'd12 : exp_pad + 4'd1;
            push_exp($sformatf("pad_left%0d", i), 3'd2, 3'd3, 0);
            wait_step();
        end

        // 6: clear every brick bottom-up, one per step, then WIN
        for (int r = 3; r >= 0; r--) begin
            for (int c = 0; c < 16; c++) begin
                applyStimulus(4'(r + 1), 4'(c), 2'b01, 1'b0, 1'b0);
                exp_bricks[r * 16 + c] = 1'b0;
                exp_score++;
                push_exp($sformatf("clear_r%0d_c%0d", r, c), 3'd2, 3'd3, exp_score);
                wait_step();
            end
        end
        @(posedge clock);
        #1;
        checkOutput("win.state", 192'(game_state), 192'(4));
        checkOutput("win.ball_reset", 192'(ball_reset), 192'(0));
        checkOutput("win.field", field_data, exp_field());

        // 6b: reset asserted in the middle of RUN
        start_pulse();
        start_pulse();
        start_pulse();
        exp_bricks = {128'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        exp_pad    = 4'd6;
        checkOutput("rerun.state", 192'(game_state), 192'(2));
        applyStimulus(4'd4, 4'd5, 2'b00, 1'b1, 1'b0);
        exp_bricks[53] = 1'b0;
        exp_pad = 4'd7;
        push_exp("prereset", 3'd2, 3'd3, 1);
        wait_step();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("midrun_rst.state", 192'(game_state), 192'(0));
        checkOutput("midrun_rst.lives", 192'(lives), 192'(3));
        checkOutput("midrun_rst.score", 192'(score), 192'(0));
        checkOutput("midrun_rst.paddle", 192'(paddle_col), 192'(6));
        checkOutput("midrun_rst.ball_reset", 192'(ball_reset), 192'(0));
        checkOutput("midrun_rst.ball_step", 192'(ball_step), 192'(0));
        checkOutput("midrun_rst.field", field_data, {6'd0, 4'hF, 118'd0, 64'hFFFF_FFFF_FFFF_FFFF});
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        checkOutput("queue_drained", 192'(exp_q.size()), 192'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
